// File: rtl/seq_app_div_ctrl.sv
// Sequential 16/8 approximate restoring divider: one shared 8-cell subtract row,
// one quotient bit per cycle (MSB first), with an LSB approximation schedule.
module seq_app_div_ctrl #(
  parameter int EXACT_ROWS = 3,
  parameter int MAX_APPROX = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] x,
  input  logic [7:0]  y,
  input  logic        approx_en,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  q,
  output logic [7:0]  r,
  output logic        dz,
  output logic        ovf,
  output logic [2:0]  iter
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  y_lat;
  logic        ax_lat;
  logic [6:0]  x_lat;
  logic [8:0]  p;
  logic [7:0]  apx;
  logic [7:0]  bin_vec;
  logic        bout_msb;
  logic        qs;
  logic [7:0]  rem;

  // Cell j of row i is approximate when it falls inside the growing LSB window.
  function automatic logic cell_is_apx(input int i, input int j);
    return (i >= EXACT_ROWS) && (j <= i - EXACT_ROWS) && (j < MAX_APPROX);
  endfunction

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);

  always_comb begin
    logic c;
    apx     = '0;
    bin_vec = '0;
    c       = 1'b0;
    for (int j = 0; j < 8; j++) begin
      apx[j]     = ax_lat && cell_is_apx(int'(iter), j);
      bin_vec[j] = c;
      if (apx[j])
        c = y_lat[j] | (~p[j] & c);
      else
        c = (~p[j] & c) | (~p[j] & y_lat[j]) | (y_lat[j] & c);
    end
    bout_msb = c;
  end

  // The approximate cell's remainder select is intentionally inverted relative to the exact cell.
  always_comb begin
    qs  = ~bout_msb | p[8];
    rem = '0;
    for (int j = 0; j < 8; j++) begin
      if (apx[j])
        rem[j] = qs ? p[j] : ((p[j] ^ y_lat[j]) | bin_vec[j]);
      else
        rem[j] = qs ? (p[j] ^ y_lat[j] ^ bin_vec[j]) : p[j];
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (in_valid) state_nxt = S_RUN;
      S_RUN:   if (dz || (iter == 3'd7)) state_nxt = S_DONE;
      S_DONE:  if (out_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      y_lat  <= '0;
      ax_lat <= 1'b0;
      x_lat  <= '0;
      p      <= '0;
      q      <= '0;
      r      <= '0;
      dz     <= 1'b0;
      ovf    <= 1'b0;
      iter   <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            y_lat  <= y;
            ax_lat <= approx_en;
            x_lat  <= x[6:0];
            p      <= x[15:7];
            ovf    <= (x[15:8] >= y);
            dz     <= (y == 8'd0);
            iter   <= 3'd0;
            q      <= 8'd0;
            r      <= 8'd0;
          end
        end
        S_RUN: begin
          // A zero divisor spends its single RUN cycle publishing the saturated result.
          if (dz) begin
            q <= 8'hFF;
            r <= p[8:1];
          end else begin
            q[3'd7 - iter] <= qs;
            if (iter != 3'd7) begin
              p     <= {rem, x_lat[6]};
              x_lat <= {x_lat[5:0], 1'b0};
              iter  <= iter + 3'd1;
            end else begin
              r <= rem;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_app_div_ctrl.sv
// Self-checking bench for seq_app_div_ctrl: directed vectors, zero divisor, overflow,
// randomized approximate sweep against a cell-level reference, hold and mid-run reset.
module tb_seq_app_div_ctrl;

  localparam int ER = 3;
  localparam int MA = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] x;
  logic [7:0]  y;
  logic        approx_en;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  q;
  logic [7:0]  r;
  logic        dz;
  logic        ovf;
  logic [2:0]  iter;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  seq_app_div_ctrl #(.EXACT_ROWS(ER), .MAX_APPROX(MA)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .approx_en(approx_en), .out_valid(out_valid),
    .out_ready(out_ready), .q(q), .r(r), .dz(dz), .ovf(ovf), .iter(iter)
  );

  // Reference: long division with an explicit per-cell borrow chain and the schedule rule.
  function automatic void ref_div(input logic [15:0] xv, input logic [7:0] yv, input bit ae,
                                  output logic [7:0] qm, output logic [7:0] rm);
    int p, k, rem, qacc;
    bit a, b, c, qs;
    bit [7:0] bin_s;
    qm = 8'h00;
    rm = 8'h00;
    if (yv == 8'd0) begin
      qm = 8'hFF;
      rm = xv[15:8];
      return;
    end
    p    = int'(xv >> 7);
    qacc = 0;
    rem  = 0;
    for (int i = 0; i < 8; i++) begin
      if (!ae || i < ER) k = 0;
      else k = (i - ER + 1 < MA) ? (i - ER + 1) : MA;
      c = 1'b0;
      for (int j = 0; j < 8; j++) begin
        a = p[j];
        b = yv[j];
        bin_s[j] = c;
        if (j < k) c = b | (!a & c);
        else       c = (!a & c) | (!a & b) | (b & c);
      end
      qs  = !c || p[8];
      rem = 0;
      for (int j = 0; j < 8; j++) begin
        a = p[j];
        b = yv[j];
        if (j < k) rem[j] = qs ? a : ((a ^ b) | bin_s[j]);
        else       rem[j] = qs ? (a ^ b ^ bin_s[j]) : a;
      end
      qacc = qacc * 2 + int'(qs);
      if (i < 7) p = rem * 2 + int'(xv[6 - i]);
    end
    qm = qacc[7:0];
    rm = rem[7:0];
  endfunction

  // Present an operand, wait for acceptance, then count edges until out_valid (bounded).
  task automatic do_op(input logic [15:0] xv, input logic [7:0] yv, input bit ae, output int lat);
    int n;
    @(negedge clk);
    x = xv; y = yv; approx_en = ae; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 30) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic release_result(output logic rdy_after, output logic ov_after);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    rdy_after = in_ready;
    ov_after  = out_valid;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; x = '0; y = '0; approx_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({in_ready, out_valid, q, r, dz, ovf, iter} !== {1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 3'd0}) begin
      n_bad++;
      $display("FAIL reset_state: got rdy=%b ov=%b q=%h r=%h dz=%b ovf=%b it=%0d, want rdy=1 ov=0 rest 0",
               in_ready, out_valid, q, r, dz, ovf, iter);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_exact_directed;
    logic [15:0] tx[3] = '{16'h1234, 16'h7FFF, 16'h00FF};
    logic [7:0]  ty[3] = '{8'h56, 8'h80, 8'h01};
    logic [7:0]  tq[3] = '{8'h36, 8'hFF, 8'hFF};
    logic [7:0]  tr[3] = '{8'h10, 8'h7F, 8'h00};
    int lat;
    logic rdy, ov;
    for (int t = 0; t < 3; t++) begin
      do_op(tx[t], ty[t], 1'b0, lat);
      n_cmp++;
      if (lat !== 8) begin
        n_bad++; $display("FAIL exact_latency[%0d]: got %0d want 8", t, lat);
      end
      n_cmp++;
      if ({q, r, ovf, dz} !== {tq[t], tr[t], 1'b0, 1'b0}) begin
        n_bad++;
        $display("FAIL exact_result[%0d]: got q=%h r=%h ovf=%b dz=%b want q=%h r=%h ovf=0 dz=0",
                 t, q, r, ovf, dz, tq[t], tr[t]);
      end
      release_result(rdy, ov);
      n_cmp++;
      if ({rdy, ov} !== 2'b10) begin
        n_bad++; $display("FAIL back_to_back_ready[%0d]: got rdy=%b ov=%b want rdy=1 ov=0", t, rdy, ov);
      end
    end
  endtask

  task automatic test_div_zero;
    int lat;
    logic rdy, ov;
    do_op(16'hABCD, 8'h00, 1'b1, lat);
    n_cmp++;
    if (lat !== 1) begin
      n_bad++; $display("FAIL dz_latency: got %0d want 1", lat);
    end
    n_cmp++;
    if ({dz, q, r, ovf} !== {1'b1, 8'hFF, 8'hAB, 1'b1}) begin
      n_bad++; $display("FAIL dz_result: got dz=%b q=%h r=%h ovf=%b want dz=1 q=ff r=ab ovf=1", dz, q, r, ovf);
    end
    release_result(rdy, ov);
  endtask

  task automatic test_overflow;
    logic [7:0] qm, rm;
    int lat;
    logic rdy, ov;
    for (int ae = 0; ae < 2; ae++) begin
      ref_div(16'hFF00, 8'hFF, ae[0], qm, rm);
      do_op(16'hFF00, 8'hFF, ae[0], lat);
      n_cmp++;
      if ({lat == 8, ovf, dz} !== 3'b110) begin
        n_bad++; $display("FAIL ovf_flags[ae=%0d]: got lat=%0d ovf=%b dz=%b want lat=8 ovf=1 dz=0", ae, lat, ovf, dz);
      end
      n_cmp++;
      if ({q, r} !== {qm, rm}) begin
        n_bad++; $display("FAIL ovf_result[ae=%0d]: got q=%h r=%h want q=%h r=%h", ae, q, r, qm, rm);
      end
      release_result(rdy, ov);
    end
  endtask

  task automatic test_random_sweep;
    logic [15:0] xv;
    logic [7:0]  yv, qm, rm;
    bit          ae, eovf;
    int          lat;
    logic        rdy, ov;
    for (int n = 0; n < 2000; n++) begin
      xv = 16'($urandom);
      yv = ($urandom_range(0, 49) == 0) ? 8'h00 : 8'($urandom);
      if ($urandom_range(0, 3) == 0) xv[15:8] = 8'($urandom_range(0, 3));
      ae = ($urandom_range(0, 3) != 0);
      eovf = (xv[15:8] >= yv);
      ref_div(xv, yv, ae, qm, rm);
      do_op(xv, yv, ae, lat);
      n_cmp++;
      if ({lat, dz, ovf} !== {((yv == 0) ? 32'd1 : 32'd8), (yv == 8'h00), eovf}) begin
        n_bad++;
        $display("FAIL rand_flags[%0d]: x=%h y=%h got lat=%0d dz=%b ovf=%b want dz=%b ovf=%b",
                 n, xv, yv, lat, dz, ovf, (yv == 8'h00), eovf);
      end
      n_cmp++;
      if ({q, r} !== {qm, rm}) begin
        n_bad++;
        $display("FAIL rand_result[%0d]: x=%h y=%h ae=%b got q=%h r=%h want q=%h r=%h",
                 n, xv, yv, ae, q, r, qm, rm);
      end
      if (!ae && !eovf && yv != 8'h00) begin
        n_cmp++;
        if ({q, r} !== {8'(xv / yv), 8'(xv % yv)}) begin
          n_bad++;
          $display("FAIL rand_exact_int[%0d]: x=%h y=%h got q=%h r=%h want q=%h r=%h",
                   n, xv, yv, q, r, 8'(xv / yv), 8'(xv % yv));
        end
      end
      release_result(rdy, ov);
    end
  endtask

  task automatic test_hold_and_abort;
    logic [7:0] qm, rm;
    int lat, n;
    logic rdy, ov;
    ref_div(16'h3C5A, 8'h9B, 1'b1, qm, rm);
    do_op(16'h3C5A, 8'h9B, 1'b1, lat);
    @(negedge clk);
    in_valid = 1'b1; x = 16'h1111; y = 8'h22;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      n_cmp++;
      if ({out_valid, in_ready, q, r, dz, ovf} !== {1'b1, 1'b0, qm, rm, 1'b0, 1'b0}) begin
        n_bad++;
        $display("FAIL hold[%0d]: got ov=%b rdy=%b q=%h r=%h dz=%b ovf=%b want ov=1 rdy=0 q=%h r=%h",
                 c, out_valid, in_ready, q, r, dz, ovf, qm, rm);
      end
    end
    in_valid = 1'b0;
    release_result(rdy, ov);

    ref_div(16'h0F37, 8'h2D, 1'b0, qm, rm);
    @(negedge clk);
    x = 16'h0F37; y = 8'h2D; approx_en = 1'b0; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({q, in_ready, out_valid} !== {qm[7:5], 5'b00000, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL partial_q: got q=%h rdy=%b ov=%b want q=%h rdy=0 ov=0",
               q, in_ready, out_valid, {qm[7:5], 5'b00000});
    end
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({in_ready, out_valid, q, iter} !== {1'b1, 1'b0, 8'h00, 3'd0}) begin
      n_bad++;
      $display("FAIL abort_reset: got rdy=%b ov=%b q=%h it=%0d want rdy=1 ov=0 q=00 it=0",
               in_ready, out_valid, q, iter);
    end
    @(negedge clk);
    rst = 1'b0;
    do_op(16'h0F37, 8'h2D, 1'b0, lat);
    n_cmp++;
    if ({lat == 8, q, r} !== {1'b1, qm, rm}) begin
      n_bad++;
      $display("FAIL after_abort: got lat=%0d q=%h r=%h want lat=8 q=%h r=%h", lat, q, r, qm, rm);
    end
    release_result(rdy, ov);
  endtask

  initial begin
    test_reset();
    test_exact_directed();
    test_div_zero();
    test_overflow();
    test_random_sweep();
    test_hold_and_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
